// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared types for the register-file writeback path: widths, queue entry layout
// and the producer identifiers used by the round-robin arbiter.
package regfile_writeback_arbiter_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 4;
  localparam int WB_DEPTH  = 4;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] dest;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

  function automatic wb_src_e otherSrc(input wb_src_e src);
    return (src == SRC_ALU) ? SRC_MEM : SRC_ALU;
  endfunction

endpackage

// File: rtl/regfile_writeback_arbiter_wb_fifo.sv
// In-order write queue of writeback entries. Besides the usual push/pop interface it
// exposes per-slot valid bits and destinations so the top can run hazard compares.
module wb_fifo
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = PTR_W + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  wb_entry_t                  i_pushEntry,
  input  logic                       i_pop,
  output wb_entry_t                  o_headEntry,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [CNT_W-1:0]           o_count,
  output logic [DEPTH-1:0]           o_entryValid,
  output logic [DEPTH*WB_ADDR_W-1:0] o_entryDest
);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;
  logic [PTR_W-1:0] w_offset;

  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_headEntry = r_mem[r_rdPtr];

  // A push into a full queue is refused even if a pop frees a slot on the same edge.
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_doPush) begin
      r_mem[r_wrPtr] <= i_pushEntry;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    o_entryValid = '0;
    o_entryDest  = '0;
    w_offset     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_offset        = PTR_W'(i) - r_rdPtr;
      o_entryValid[i] = ({1'b0, w_offset} < r_count);
      o_entryDest[i*WB_ADDR_W +: WB_ADDR_W] = r_mem[i].dest;
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Writer side of the register file: round-robin merge of ALU and load results into
// an in-order queue, a registered write port, and RAW pending-write queries for decode.
module regfile_writeback_arbiter
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_alu_valid,
  output logic              o_alu_ready,
  input  logic [ADDR_W-1:0] i_alu_dest,
  input  logic [DATA_W-1:0] i_alu_data,
  input  logic              i_mem_valid,
  output logic              o_mem_ready,
  input  logic [ADDR_W-1:0] i_mem_dest,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_rf_reg_write,
  output logic [ADDR_W-1:0] o_rf_write_reg,
  output logic [DATA_W-1:0] o_rf_write_data,
  input  logic [ADDR_W-1:0] i_q_reg1,
  input  logic [ADDR_W-1:0] i_q_reg2,
  output logic              o_q_pending1,
  output logic              o_q_pending2,
  output logic              o_queue_empty
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_src_e                  r_rrPtr;
  logic                     r_rfRegWrite;
  logic [ADDR_W-1:0]        r_rfWriteReg;
  logic [DATA_W-1:0]        r_rfWriteData;

  logic                     w_full;
  logic                     w_empty;
  logic [CNT_W-1:0]         w_count;
  logic                     w_bothValid;
  logic                     w_aluGrant;
  logic                     w_memGrant;
  logic                     w_push;
  wb_entry_t                w_pushEntry;
  wb_entry_t                w_headEntry;
  logic [DEPTH-1:0]         w_entryValid;
  logic [DEPTH*ADDR_W-1:0]  w_entryDest;

  // Ready is offered to a source unless the other one is also valid and owns the turn.
  assign w_bothValid = i_alu_valid && i_mem_valid;
  assign o_alu_ready = !w_full && (!i_mem_valid || (r_rrPtr == SRC_ALU));
  assign o_mem_ready = !w_full && (!i_alu_valid || (r_rrPtr == SRC_MEM));
  assign w_aluGrant  = i_alu_valid && o_alu_ready;
  assign w_memGrant  = i_mem_valid && o_mem_ready;
  assign w_push      = w_aluGrant || w_memGrant;

  always_comb begin
    w_pushEntry = '0;
    if (w_aluGrant) begin
      w_pushEntry.dest = i_alu_dest;
      w_pushEntry.data = i_alu_data;
    end else if (w_memGrant) begin
      w_pushEntry.dest = i_mem_dest;
      w_pushEntry.data = i_mem_data;
    end
  end

  // The turn only passes on contested grants, so a lone producer never loses its slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rrPtr <= SRC_ALU;
    end else if (w_bothValid && !w_full) begin
      r_rrPtr <= otherSrc(r_rrPtr);
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_pushEntry  (w_pushEntry),
    .i_pop        (!w_empty),
    .o_headEntry  (w_headEntry),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count),
    .o_entryValid (w_entryValid),
    .o_entryDest  (w_entryDest)
  );

  // The head drains into the port register every cycle it exists; index/data hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rfRegWrite  <= 1'b0;
      r_rfWriteReg  <= '0;
      r_rfWriteData <= '0;
    end else if (!w_empty) begin
      r_rfRegWrite  <= 1'b1;
      r_rfWriteReg  <= w_headEntry.dest;
      r_rfWriteData <= w_headEntry.data;
    end else begin
      r_rfRegWrite  <= 1'b0;
    end
  end

  assign o_rf_reg_write  = r_rfRegWrite;
  assign o_rf_write_reg  = r_rfWriteReg;
  assign o_rf_write_data = r_rfWriteData;
  assign o_queue_empty   = w_empty && !r_rfRegWrite;

  // A write still sitting on the port has not reached the file yet, so it counts as pending.
  always_comb begin
    o_q_pending1 = r_rfRegWrite && (r_rfWriteReg == i_q_reg1);
    o_q_pending2 = r_rfRegWrite && (r_rfWriteReg == i_q_reg2);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entryValid[i] && (w_entryDest[i*ADDR_W +: ADDR_W] == i_q_reg1)) o_q_pending1 = 1'b1;
      if (w_entryValid[i] && (w_entryDest[i*ADDR_W +: ADDR_W] == i_q_reg2)) o_q_pending2 = 1'b1;
    end
  end

  assert property (@(posedge clk) disable iff (reset) w_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Scoreboard bench for regfile_writeback_arbiter: accepted results are queued in the
// bench and matched against every write that appears on the register file port.
module tb_regfile_writeback_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_alu_valid, i_mem_valid;
  logic        o_alu_ready, o_mem_ready;
  logic [3:0]  i_alu_dest, i_mem_dest;
  logic [15:0] i_alu_data, i_mem_data;
  logic        o_rf_reg_write;
  logic [3:0]  o_rf_write_reg;
  logic [15:0] o_rf_write_data;
  logic [3:0]  i_q_reg1, i_q_reg2;
  logic        o_q_pending1, o_q_pending2, o_queue_empty;

  typedef struct packed {
    logic [3:0]  dest;
    logic [15:0] data;
  } tbEntry_t;

  tbEntry_t fifoQ[$];
  tbEntry_t expQ[$];
  logic     modelPortValid;
  tbEntry_t modelPort;
  logic     modelPtrMem;
  int       testsRun = 0;
  int       testsFailed = 0;

  always #5 clk = ~clk;

  regfile_writeback_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .i_alu_valid     (i_alu_valid),
    .o_alu_ready     (o_alu_ready),
    .i_alu_dest      (i_alu_dest),
    .i_alu_data      (i_alu_data),
    .i_mem_valid     (i_mem_valid),
    .o_mem_ready     (o_mem_ready),
    .i_mem_dest      (i_mem_dest),
    .i_mem_data      (i_mem_data),
    .o_rf_reg_write  (o_rf_reg_write),
    .o_rf_write_reg  (o_rf_write_reg),
    .o_rf_write_data (o_rf_write_data),
    .i_q_reg1        (i_q_reg1),
    .i_q_reg2        (i_q_reg2),
    .o_q_pending1    (o_q_pending1),
    .o_q_pending2    (o_q_pending2),
    .o_queue_empty   (o_queue_empty)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic modelPending(input logic [3:0] r);
    logic hit;
    hit = modelPortValid && (modelPort.dest == r);
    foreach (fifoQ[i]) if (fifoQ[i].dest == r) hit = 1'b1;
    return hit;
  endfunction

  // One clock cycle: drive at the falling edge, check combinational outputs, advance the
  // model at the rising edge, then check the registered write port at the next falling edge.
  task automatic applyStimulus(input logic aV, input logic [3:0] aD, input logic [15:0] aDat,
                               input logic mV, input logic [3:0] mD, input logic [15:0] mDat,
                               input logic [3:0] q1, input logic [3:0] q2);
    logic     full, aR, mR, accValid;
    tbEntry_t acc, got;
    i_alu_valid = aV; i_alu_dest = aD; i_alu_data = aDat;
    i_mem_valid = mV; i_mem_dest = mD; i_mem_data = mDat;
    i_q_reg1 = q1; i_q_reg2 = q2;
    #1;
    full = (fifoQ.size() >= DEPTH);
    aR = !full && (!mV || !modelPtrMem);
    mR = !full && (!aV || modelPtrMem);
    checkOutput("alu_ready", o_alu_ready, aR);
    checkOutput("mem_ready", o_mem_ready, mR);
    checkOutput("q_pending1", o_q_pending1, modelPending(q1));
    checkOutput("q_pending2", o_q_pending2, modelPending(q2));
    checkOutput("queue_empty", o_queue_empty, (fifoQ.size() == 0) && !modelPortValid);
    accValid = 1'b0;
    acc = '0;
    if (aV && aR) begin
      acc = {aD, aDat}; accValid = 1'b1;
    end else if (mV && mR) begin
      acc = {mD, mDat}; accValid = 1'b1;
    end
    if (accValid) expQ.push_back(acc);
    @(posedge clk);
    if (fifoQ.size() > 0) begin
      modelPortValid = 1'b1;
      modelPort = fifoQ.pop_front();
    end else begin
      modelPortValid = 1'b0;
    end
    if (accValid) fifoQ.push_back(acc);
    if (aV && mV && !full) modelPtrMem = !modelPtrMem;
    @(negedge clk);
    checkOutput("rf_reg_write", o_rf_reg_write, modelPortValid);
    if (o_rf_reg_write === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_underflow", o_rf_reg_write, 1'b0);
      end else begin
        got = expQ.pop_front();
        checkOutput("rf_write_reg", o_rf_write_reg, got.dest);
        checkOutput("rf_write_data", o_rf_write_data, got.data);
      end
    end
  endtask

  task automatic idle(input int n, input logic [3:0] q1, input logic [3:0] q2);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, q1, q2);
  endtask

  task automatic resetMidOperation();
    i_alu_valid = 1'b0;
    i_mem_valid = 1'b0;
    i_q_reg1 = 4'd1;
    i_q_reg2 = 4'd3;
    reset = 1'b1;
    #1;
    checkOutput("rst_rf_reg_write", o_rf_reg_write, 1'b0);
    checkOutput("rst_queue_empty", o_queue_empty, 1'b1);
    checkOutput("rst_q_pending1", o_q_pending1, 1'b0);
    checkOutput("rst_q_pending2", o_q_pending2, 1'b0);
    fifoQ.delete();
    expQ.delete();
    modelPortValid = 1'b0;
    modelPtrMem = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    i_alu_valid = 1'b0; i_alu_dest = '0; i_alu_data = '0;
    i_mem_valid = 1'b0; i_mem_dest = '0; i_mem_data = '0;
    i_q_reg1 = '0; i_q_reg2 = '0;
    modelPortValid = 1'b0;
    modelPort = '0;
    modelPtrMem = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rf_reg_write", o_rf_reg_write, 1'b0);
    checkOutput("reset_rf_write_reg", o_rf_write_reg, 4'd0);
    checkOutput("reset_rf_write_data", o_rf_write_data, 16'h0);
    checkOutput("reset_queue_empty", o_queue_empty, 1'b1);
    checkOutput("reset_alu_ready", o_alu_ready, 1'b1);
    reset = 1'b0;

    // Single ALU write, watching reg 3 go pending and clear again.
    applyStimulus(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0, 4'd3, 4'd0);
    idle(4, 4'd3, 4'd0);

    // Contested producers: ALU first, then MEM.
    applyStimulus(1'b1, 4'd5, 16'h00AA, 1'b1, 4'd6, 16'h00BB, 4'd5, 4'd6);
    applyStimulus(1'b1, 4'd5, 16'h00AA, 1'b1, 4'd6, 16'h00BB, 4'd5, 4'd6);
    idle(4, 4'd5, 4'd6);

    // MEM streaming back-to-back with ALU idle.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'(7 + i), 16'(16'h0C00 + i), 4'd7, 4'd10);
    idle(4, 4'd7, 4'd10);

    // Two writes to the same register, including dest 0 as a second query.
    applyStimulus(1'b1, 4'd2, 16'h0001, 1'b0, 4'd0, 16'h0, 4'd2, 4'd0);
    applyStimulus(1'b1, 4'd2, 16'h0002, 1'b0, 4'd0, 16'h0, 4'd2, 4'd0);
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'hBEEF, 4'd2, 4'd0);
    idle(4, 4'd2, 4'd0);

    // Reset with writes in flight, then a fresh push afterwards.
    applyStimulus(1'b1, 4'd1, 16'h1111, 1'b0, 4'd0, 16'h0, 4'd1, 4'd3);
    applyStimulus(1'b1, 4'd2, 16'h2222, 1'b0, 4'd0, 16'h0, 4'd1, 4'd3);
    applyStimulus(1'b1, 4'd3, 16'h3333, 1'b0, 4'd0, 16'h0, 4'd1, 4'd3);
    resetMidOperation();
    idle(2, 4'd1, 4'd3);
    applyStimulus(1'b1, 4'd9, 16'h9999, 1'b0, 4'd0, 16'h0, 4'd9, 4'd3);
    idle(3, 4'd9, 4'd3);

    // Random traffic from both producers with random hazard queries.
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    idle(4, 4'd0, 4'd15);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
